// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma front-end stepper.
// Letter width, alphabet size, state encoding and default notches.
package enigma_pkg;

  localparam int LETTER_W = 5;
  localparam int ALPHA    = 26;

  typedef logic [LETTER_W-1:0] letter_t;

  localparam letter_t LAST_LETTER = letter_t'(ALPHA - 1);
  localparam letter_t NOTCH1_DEF  = 5'd16;
  localparam letter_t NOTCH2_DEF  = 5'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_ISSUE
  } state_e;

  // Out-of-alphabet load values collapse to position 0.
  function automatic letter_t clamp_pos(input letter_t v);
    return (v > LAST_LETTER) ? '0 : v;
  endfunction

endpackage

// File: rtl/mod26_inc.sv
// Combinational rotor increment with 25 -> 0 wrap.
// Ports: in_i position, en_i step enable, out_o next position.
module mod26_inc
  import enigma_pkg::*;
(
  input  letter_t in_i,
  input  logic    en_i,
  output letter_t out_o
);

  assign out_o = !en_i                 ? in_i :
                 (in_i == LAST_LETTER) ? '0   :
                 in_i + 5'd1;

endmodule

// File: rtl/rotor_stepper.sv
// Enigma keypress front-end: steps r1/r2/r3, presents letter to core.
// Ports: clk, reset (sync, high), key_valid/key_code/key_ready/key_err,
// load/load_r1..r3, enc_in, r1..r3, enc_valid/enc_ready.
// Build macro: DOUBLE_STEP_EN selects the Enigma double-step of r2;
// without it the rotors behave as a pure odometer.
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH1 = NOTCH1_DEF,
  parameter letter_t NOTCH2 = NOTCH2_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    key_valid,
  input  letter_t key_code,
  output logic    key_ready,
  output logic    key_err,
  input  logic    load,
  input  letter_t load_r1,
  input  letter_t load_r2,
  input  letter_t load_r3,
  output letter_t enc_in,
  output letter_t r1,
  output letter_t r2,
  output letter_t r3,
  output logic    enc_valid,
  input  logic    enc_ready
);

  state_e  state_q;
  letter_t r1_q, r2_q, r3_q;
  letter_t r1_d, r2_d, r3_d;
  letter_t enc_q;
  logic    enc_valid_q;
  logic    key_err_q;

  logic s2, d;
  logic en2, en3;

  assign s2 = (r1_q == NOTCH1);
  assign d  = (r2_q == NOTCH2);

`ifdef DOUBLE_STEP_EN
  assign en2 = s2 | d;
  assign en3 = d;
`else
  assign en2 = s2;
  assign en3 = s2 & d;
`endif

  mod26_inc u_inc1 (
    .in_i  (r1_q),
    .en_i  (1'b1),
    .out_o (r1_d)
  );

  mod26_inc u_inc2 (
    .in_i  (r2_q),
    .en_i  (en2),
    .out_o (r2_d)
  );

  mod26_inc u_inc3 (
    .in_i  (r3_q),
    .en_i  (en3),
    .out_o (r3_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      enc_q       <= '0;
      enc_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      key_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            r1_q <= clamp_pos(load_r1);
            r2_q <= clamp_pos(load_r2);
            r3_q <= clamp_pos(load_r3);
          end else if (key_valid) begin
            if (key_code <= LAST_LETTER) begin
              enc_q   <= key_code;
              state_q <= ST_STEP;
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          r1_q    <= r1_d;
          r2_q    <= r2_d;
          r3_q    <= r3_d;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // First ISSUE cycle raises valid; ready only counts once valid is up.
          if (!enc_valid_q) begin
            enc_valid_q <= 1'b1;
          end else if (enc_ready) begin
            enc_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          enc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = (state_q == ST_IDLE) && !load;
  assign key_err   = key_err_q;
  assign enc_in    = enc_q;
  assign r1        = r1_q;
  assign r2        = r2_q;
  assign r3        = r3_q;
  assign enc_valid = enc_valid_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: vector table plus corner sequences.
// Expected positions are hand-computed for the active stepping mode.
module tb_rotor_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic       key_err;
  logic       load;
  logic [4:0] load_r1, load_r2, load_r3;
  logic [4:0] enc_in;
  logic [4:0] r1, r2, r3;
  logic       enc_valid;
  logic       enc_ready;

  int n_vec = 0;
  int n_err = 0;

  rotor_stepper dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_err   (key_err),
    .load      (load),
    .load_r1   (load_r1),
    .load_r2   (load_r2),
    .load_r3   (load_r3),
    .enc_in    (enc_in),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [4:0] l1, l2, l3;
    logic [4:0] key;
    logic [4:0] e1, e2, e3;
    int         hold;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pos(input string nm,
                         input logic [4:0] a,
                         input logic [4:0] b,
                         input logic [4:0] c);
    chk({nm, ".r1"}, 32'(r1), 32'(a));
    chk({nm, ".r2"}, 32'(r2), 32'(b));
    chk({nm, ".r3"}, 32'(r3), 32'(c));
  endtask

  task automatic do_load(input logic [4:0] a,
                         input logic [4:0] b,
                         input logic [4:0] c);
    load    = 1'b1;
    load_r1 = a;
    load_r2 = b;
    load_r3 = c;
    tick();
    load = 1'b0;
  endtask

  // Press one key and follow it through STEP/ISSUE with exact timing.
  task automatic run_key(input string nm,
                         input logic [4:0] k,
                         input logic [4:0] a,
                         input logic [4:0] b,
                         input logic [4:0] c,
                         input int hold);
    key_valid = 1'b1;
    key_code  = k;
    #1;
    chk({nm, ".ready"}, 32'(key_ready), 1);
    tick();
    key_valid = 1'b0;
    chk({nm, ".v_t1"}, 32'(enc_valid), 0);
    tick();
    chk({nm, ".v_t2"}, 32'(enc_valid), 0);
    tick();
    chk({nm, ".valid"}, 32'(enc_valid), 1);
    chk({nm, ".enc"}, 32'(enc_in), 32'(k));
    chk_pos(nm, a, b, c);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({nm, ".hold_v"}, 32'(enc_valid), 1);
      chk({nm, ".hold_e"}, 32'(enc_in), 32'(k));
      chk_pos({nm, ".hold"}, a, b, c);
    end
    enc_ready = 1'b1;
    tick();
    enc_ready = 1'b0;
    chk({nm, ".drop"}, 32'(enc_valid), 0);
    chk({nm, ".idle"}, 32'(key_ready), 1);
    chk({nm, ".err"}, 32'(key_err), 0);
    chk_pos({nm, ".after"}, a, b, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd0, 5'd0, 5'd0, 5'd7, 5'd1, 5'd0, 5'd0, 5};
    tbl[1] = '{1'b1, 5'd15, 5'd3, 5'd0, 5'd1, 5'd16, 5'd3, 5'd0, 0};
    tbl[2] = '{1'b0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd17, 5'd4, 5'd0, 1};
`ifdef DOUBLE_STEP_EN
    tbl[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd18, 5'd5, 5'd1, 0};
    tbl[7] = '{1'b1, 5'd3, 5'd4, 5'd9, 5'd10, 5'd4, 5'd5, 5'd10, 0};
`else
    tbl[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd18, 5'd4, 5'd0, 0};
    tbl[7] = '{1'b1, 5'd3, 5'd4, 5'd9, 5'd10, 5'd4, 5'd4, 5'd9, 0};
`endif
    tbl[4] = '{1'b1, 5'd16, 5'd4, 5'd25, 5'd25, 5'd17, 5'd5, 5'd0, 0};
    tbl[5] = '{1'b1, 5'd25, 5'd25, 5'd25, 5'd0, 5'd0, 5'd25, 5'd25, 0};
    tbl[6] = '{1'b1, 5'd30, 5'd26, 5'd31, 5'd4, 5'd1, 5'd0, 5'd0, 0};
    tbl[8] = '{1'b1, 5'd16, 5'd12, 5'd2, 5'd12, 5'd17, 5'd13, 5'd2, 0};
    tbl[9] = '{1'b1, 5'd16, 5'd25, 5'd7, 5'd5, 5'd17, 5'd0, 5'd7, 0};

    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 5'd5;
    load      = 1'b0;
    load_r1   = '0;
    load_r2   = '0;
    load_r3   = '0;
    enc_ready = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    key_valid = 1'b0;
    #1;
    chk("rst.ready", 32'(key_ready), 1);
    chk("rst.valid", 32'(enc_valid), 0);
    chk("rst.err", 32'(key_err), 0);
    chk("rst.enc", 32'(enc_in), 0);
    chk_pos("rst", 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].ld) do_load(tbl[i].l1, tbl[i].l2, tbl[i].l3);
      run_key($sformatf("vec%0d", i), tbl[i].key,
              tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].hold);
    end

    do_load(5'd5, 5'd6, 5'd7);
    key_valid = 1'b1;
    key_code  = 5'd30;
    tick();
    key_valid = 1'b0;
    chk("kerr.pulse", 32'(key_err), 1);
    chk("kerr.ready", 32'(key_ready), 1);
    tick();
    chk("kerr.clear", 32'(key_err), 0);
    tick();
    tick();
    chk("kerr.valid", 32'(enc_valid), 0);
    chk_pos("kerr", 5, 6, 7);

    load      = 1'b1;
    load_r1   = 5'd9;
    load_r2   = 5'd10;
    load_r3   = 5'd11;
    key_valid = 1'b1;
    key_code  = 5'd3;
    #1;
    chk("ldkey.ready", 32'(key_ready), 0);
    tick();
    load      = 1'b0;
    key_valid = 1'b0;
    chk_pos("ldkey", 9, 10, 11);
    tick();
    tick();
    tick();
    chk("ldkey.valid", 32'(enc_valid), 0);
    chk_pos("ldkey.late", 9, 10, 11);

    key_valid = 1'b1;
    key_code  = 5'd8;
    tick();
    key_valid = 1'b0;
    load      = 1'b1;
    load_r1   = 5'd20;
    load_r2   = 5'd20;
    load_r3   = 5'd20;
    tick();
    tick();
    chk("ldbusy.valid", 32'(enc_valid), 1);
    chk_pos("ldbusy", 10, 10, 11);
    tick();
    chk_pos("ldbusy.hold", 10, 10, 11);
    load      = 1'b0;
    enc_ready = 1'b1;
    tick();
    enc_ready = 1'b0;
    chk("ldbusy.drop", 32'(enc_valid), 0);

    do_load(5'd5, 5'd5, 5'd5);
    key_valid = 1'b1;
    key_code  = 5'd9;
    tick();
    key_valid = 1'b0;
    tick();
    tick();
    chk("rsti.valid", 32'(enc_valid), 1);
    chk_pos("rsti.pre", 6, 5, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rsti.drop", 32'(enc_valid), 0);
    chk("rsti.enc", 32'(enc_in), 0);
    chk_pos("rsti", 0, 0, 0);
    run_key("fresh", 5'd2, 5'd1, 5'd0, 5'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
